// File: rtl/vjtag_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : vjtag_bus_arb
// Purpose  : Two-requester (JTAG host / core) round-robin arbiter onto a
//            single slave bus. Keeps at most one transaction in flight and
//            returns read data, or a timeout error response, to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module vjtag_bus_arb #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_req_valid,
    input  logic [2*ADDR_WIDTH-1:0] m_req_addr,
    input  logic [1:0]              m_req_write,
    input  logic [2*DATA_WIDTH-1:0] m_req_wdata,
    output logic [1:0]              m_req_ready,
    output logic [1:0]              m_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m_rsp_rdata,
    output logic                    m_rsp_err,
    output logic                    s_req_valid,
    output logic [ADDR_WIDTH-1:0]   s_req_addr,
    output logic                    s_req_write,
    output logic [DATA_WIDTH-1:0]   s_req_wdata,
    input  logic                    s_req_ready,
    input  logic                    s_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   s_rsp_rdata,
    output logic                    busy
);

    localparam int               CNT_W     = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(RSP_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic                  in_gnt;
    logic                  in_rsp;
    logic                  own_valid;
    logic                  own_write;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;
    logic                  arb_winner;
    logic                  req_hs;
    logic                  rsp_hit;
    logic                  tmo_hit;

    assign in_gnt = (state_q == ST_GNT);
    assign in_rsp = (state_q == ST_RSP);

    // Owner's request fields; only the owner's slice can ever reach the slave
    assign own_valid = owner_q ? m_req_valid[1] : m_req_valid[0];
    assign own_write = owner_q ? m_req_write[1] : m_req_write[0];
    assign own_addr  = owner_q ? m_req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                               : m_req_addr[ADDR_WIDTH-1:0];
    assign own_wdata = owner_q ? m_req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                               : m_req_wdata[DATA_WIDTH-1:0];

    // Tie goes to whoever did not complete the last transfer
    assign arb_winner = (&m_req_valid) ? ~last_owner_q : m_req_valid[1];

    assign req_hs  = in_gnt & own_valid & s_req_ready;
    assign rsp_hit = in_rsp & s_rsp_valid;
    // A real response in the expiry cycle takes priority over the timeout
    assign tmo_hit = in_rsp & ~s_rsp_valid & (tmo_cnt_q == TMO_LIMIT);

    assign s_req_valid = in_gnt & own_valid;
    assign s_req_addr  = own_addr;
    assign s_req_write = own_write;
    assign s_req_wdata = own_wdata;

    assign m_req_ready = !in_gnt ? 2'b00
                       : (owner_q ? {s_req_ready, 1'b0} : {1'b0, s_req_ready});
    assign m_rsp_valid = !(rsp_hit | tmo_hit) ? 2'b00
                       : (owner_q ? 2'b10 : 2'b01);
    assign m_rsp_rdata = rsp_hit ? s_rsp_rdata : '0;
    assign m_rsp_err   = tmo_hit;
    assign busy        = (state_q != ST_IDLE);

    // Transaction sequencing: arbitrate, present request, await response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|m_req_valid) begin
                        owner_q <= arb_winner;
                        state_q <= ST_GNT;
                    end
                end
                ST_GNT: begin
                    if (req_hs) begin
                        last_owner_q <= owner_q;
                        tmo_cnt_q    <= '0;
                        state_q      <= own_write ? ST_IDLE : ST_RSP;
                    end else if (!own_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RSP: begin
                    if (rsp_hit || tmo_hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vjtag_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vjtag_bus_arb
// Purpose  : Self-checking bench for vjtag_bus_arb: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vjtag_bus_arb;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic            clk;
    logic            rst;
    logic [1:0]      m_req_valid;
    logic [2*AW-1:0] m_req_addr;
    logic [1:0]      m_req_write;
    logic [2*DW-1:0] m_req_wdata;
    logic [1:0]      m_req_ready;
    logic [1:0]      m_rsp_valid;
    logic [DW-1:0]   m_rsp_rdata;
    logic            m_rsp_err;
    logic            s_req_valid;
    logic [AW-1:0]   s_req_addr;
    logic            s_req_write;
    logic [DW-1:0]   s_req_wdata;
    logic            s_req_ready;
    logic            s_rsp_valid;
    logic [DW-1:0]   s_rsp_rdata;
    logic            busy;

    int tests = 0;
    int fails = 0;

    vjtag_bus_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_valid(m_req_valid),
        .m_req_addr (m_req_addr),
        .m_req_write(m_req_write),
        .m_req_wdata(m_req_wdata),
        .m_req_ready(m_req_ready),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err  (m_rsp_err),
        .s_req_valid(s_req_valid),
        .s_req_addr (s_req_addr),
        .s_req_write(s_req_write),
        .s_req_wdata(s_req_wdata),
        .s_req_ready(s_req_ready),
        .s_rsp_valid(s_rsp_valid),
        .s_rsp_rdata(s_rsp_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the transaction in flight (who holds the
    // bus, whether a read is pending and since which cycle), and derives
    // the required outputs from that each cycle.
    // ------------------------------------------------------------------
    int   cyc          = 0;
    bit   model_ok     = 0;
    bit   granted      = 0;   // a requester holds the bus
    bit   awaiting     = 0;   // a read was accepted and awaits its data
    int   holder       = 0;
    int   prev_winner  = 1;
    int   wait_from    = 0;   // first cycle spent awaiting read data

    always @(negedge clk) begin
        logic          e_busy, e_sv, e_err;
        logic [1:0]    e_rdy, e_rv;
        logic [DW-1:0] e_rd;
        cyc++;
        if (model_ok) begin
            e_busy = granted || awaiting;
            e_sv = 0; e_rdy = 0; e_rv = 0; e_err = 0; e_rd = 0;
            if (granted) begin
                e_sv = m_req_valid[holder];
                e_rdy[holder] = s_req_ready;
            end
            if (awaiting) begin
                if (s_rsp_valid) begin
                    e_rv[holder] = 1'b1;
                    e_rd = s_rsp_rdata;
                end else if (cyc - wait_from == TMO) begin
                    e_rv[holder] = 1'b1;
                    e_err = 1'b1;
                end
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("s_req_valid", 64'(s_req_valid), 64'(e_sv));
            chk("m_req_ready", 64'(m_req_ready), 64'(e_rdy));
            chk("m_rsp_valid", 64'(m_rsp_valid), 64'(e_rv));
            chk("m_rsp_err", 64'(m_rsp_err), 64'(e_err));
            if (e_sv) begin
                chk("s_req_addr", 64'(s_req_addr), 64'(m_req_addr[holder*AW +: AW]));
                chk("s_req_wdata", 64'(s_req_wdata), 64'(m_req_wdata[holder*DW +: DW]));
                chk("s_req_write", 64'(s_req_write), 64'(m_req_write[holder]));
            end
            if (e_rv != 0)
                chk("m_rsp_rdata", 64'(m_rsp_rdata), 64'(e_rd));
        end
        // advance to what the next clock edge will produce
        if (rst) begin
            model_ok    = 1;
            granted     = 0;
            awaiting    = 0;
            prev_winner = 1;
        end else if (model_ok) begin
            if (awaiting) begin
                if (s_rsp_valid || (cyc - wait_from == TMO)) awaiting = 0;
            end else if (granted) begin
                if (m_req_valid[holder] && s_req_ready) begin
                    granted     = 0;
                    prev_winner = holder;
                    if (!m_req_write[holder]) begin
                        awaiting  = 1;
                        wait_from = cyc + 1;
                    end
                end else if (!m_req_valid[holder]) begin
                    granted = 0;
                end
            end else if (m_req_valid != 0) begin
                granted = 1;
                if (m_req_valid == 2'b11) holder = 1 - prev_winner;
                else                      holder = m_req_valid[1] ? 1 : 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req_valid = 0; m_req_write = 0; m_req_addr = 0; m_req_wdata = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        nxt();
        nxt();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #2;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_req_valid", 64'(s_req_valid), 64'd0);
        chk("rst_m_req_ready", 64'(m_req_ready), 64'd0);
        chk("rst_m_rsp_valid", 64'(m_rsp_valid), 64'd0);
        nxt();

        // single write from requester 0
        m_req_valid = 2'b01; m_req_write = 2'b01; s_req_ready = 1;
        m_req_addr = {16'h0000, 16'h1234}; m_req_wdata = {16'h0000, 16'hBEEF};
        nxt();
        @(negedge clk);
        chk("wr_s_req_valid", 64'(s_req_valid), 64'd1);
        chk("wr_s_req_addr", 64'(s_req_addr), 64'h1234);
        chk("wr_s_req_wdata", 64'(s_req_wdata), 64'hBEEF);
        chk("wr_m_req_ready", 64'(m_req_ready), 64'b01);
        nxt();
        m_req_valid = 0;
        @(negedge clk);
        chk("wr_busy_after", 64'(busy), 64'd0);
        nxt();

        // read by requester 1 with 3-cycle slave latency
        m_req_valid = 2'b10; m_req_write = 2'b00; s_req_ready = 1;
        m_req_addr = {16'h0040, 16'h0000};
        nxt();
        @(negedge clk);
        chk("rd_s_req_addr", 64'(s_req_addr), 64'h0040);
        chk("rd_m_req_ready", 64'(m_req_ready), 64'b10);
        nxt();
        m_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rd_wait_no_rsp", 64'(m_rsp_valid), 64'd0);
            nxt();
        end
        s_rsp_valid = 1; s_rsp_rdata = 16'hA5A5;
        @(negedge clk);
        chk("rd_m_rsp_valid", 64'(m_rsp_valid), 64'b10);
        chk("rd_m_rsp_rdata", 64'(m_rsp_rdata), 64'hA5A5);
        chk("rd_m_rsp_err", 64'(m_rsp_err), 64'd0);
        nxt();
        s_rsp_valid = 0;

        // round-robin with continuous writes from both, fresh after reset
        do_reset();
        m_req_valid = 2'b11; m_req_write = 2'b11; s_req_ready = 1;
        m_req_addr = {16'h2000, 16'h1000};
        for (int i = 0; i < 4; i++) begin
            nxt();
            @(negedge clk);
            chk("rr_grant", 64'(m_req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            chk("rr_addr", 64'(s_req_addr), (i % 2 == 0) ? 64'h1000 : 64'h2000);
            nxt();
            @(negedge clk);
            chk("rr_idle_busy", 64'(busy), 64'd0);
        end
        m_req_valid = 0;

        // timeout: read accepted, slave never answers
        nxt();
        m_req_valid = 2'b01; m_req_write = 2'b00; m_req_addr = {16'h0000, 16'h0100};
        nxt();
        @(negedge clk);
        chk("to_m_req_ready", 64'(m_req_ready), 64'b01);
        nxt();
        m_req_valid = 0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("to_quiet", 64'(m_rsp_valid), 64'd0);
            nxt();
        end
        @(negedge clk);
        chk("to_m_rsp_valid", 64'(m_rsp_valid), 64'b01);
        chk("to_m_rsp_err", 64'(m_rsp_err), 64'd1);
        chk("to_m_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
        nxt();
        @(negedge clk);
        chk("to_busy_after", 64'(busy), 64'd0);
        chk("to_single_pulse", 64'(m_rsp_valid), 64'd0);

        // backpressure then abort by requester 1 (last completed owner is 0)
        nxt();
        m_req_valid = 2'b10; m_req_write = 2'b11; s_req_ready = 0;
        m_req_addr = {16'h3333, 16'h4444};
        for (int i = 0; i < 2; i++) begin
            nxt();
            @(negedge clk);
            chk("bp_s_req_valid", 64'(s_req_valid), 64'd1);
            chk("bp_no_ready", 64'(m_req_ready), 64'd0);
        end
        nxt();
        m_req_valid = 2'b00;
        @(negedge clk);
        chk("ab_s_req_valid", 64'(s_req_valid), 64'd0);
        chk("ab_no_ready", 64'(m_req_ready), 64'd0);
        nxt();
        m_req_valid = 2'b11;
        @(negedge clk);
        chk("ab_back_idle", 64'(busy), 64'd0);
        nxt();
        @(negedge clk);
        chk("ab_tie_to_1", 64'(s_req_addr), 64'h3333);
        nxt();
        s_req_ready = 1;
        @(negedge clk);
        chk("ab_grant_1", 64'(m_req_ready), 64'b10);
        nxt();
        m_req_valid = 0;

        // reset while awaiting read data, then a late response
        nxt();
        m_req_valid = 2'b01; m_req_write = 2'b00; s_req_ready = 1;
        nxt();
        nxt();
        m_req_valid = 0;
        @(negedge clk);
        chk("rr_in_rsp_busy", 64'(busy), 64'd1);
        nxt();
        rst = 1;
        nxt();
        rst = 0; s_rsp_valid = 1; s_rsp_rdata = 16'h1234;
        @(negedge clk);
        chk("late_rsp_ignored", 64'(m_rsp_valid), 64'd0);
        chk("late_rsp_busy", 64'(busy), 64'd0);
        nxt();
        s_rsp_valid = 0;

        // randomized traffic; response likelihood varies per segment
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                rst         = ($urandom_range(0, 299) == 0);
                m_req_valid = 2'($urandom_range(0, 3));
                m_req_write = 2'($urandom_range(0, 3));
                m_req_addr  = 32'($urandom);
                m_req_wdata = 32'($urandom);
                s_req_ready = ($urandom_range(0, 1) == 1);
                case (seg)
                    0:       s_rsp_valid = ($urandom_range(0, 1) == 1);
                    1:       s_rsp_valid = ($urandom_range(0, 9) == 0);
                    default: s_rsp_valid = 1'b0;
                endcase
                s_rsp_rdata = 16'($urandom);
                nxt();
            end
        end
        rst = 0;
        idle_inputs();
        nxt();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vjtag_bus_arb.md
VJTAG_BUS_ARB -- requirements
Module: vjtag_bus_arb

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 16, data width
- RSP_TIMEOUT, 255, maximum cycles to wait for a read response (1..65535)

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- m_req_valid  in  2  per-requester request valid; bit0 = JTAG host, bit1 = core
- m_req_addr  in  2*ADDR_WIDTH  per-requester byte address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_req_write  in  2  per-requester request type; 1 = write, 0 = read
- m_req_wdata  in  2*DATA_WIDTH  per-requester write data, sliced as for addresses
- m_req_ready  out  2  per-requester request accepted
- m_rsp_valid  out  2  per-requester read response valid, 1-cycle pulse
- m_rsp_rdata  out  DATA_WIDTH  read data, shared by both requesters
- m_rsp_err  out  1  qualifies m_rsp_valid; 1 = response produced by timeout
- s_req_valid  out  1  slave-bus request valid
- s_req_addr  out  ADDR_WIDTH  slave-bus address
- s_req_write  out  1  slave-bus request type
- s_req_wdata  out  DATA_WIDTH  slave-bus write data
- s_req_ready  in  1  slave-bus request accepted
- s_rsp_valid  in  1  slave-bus read response valid
- s_rsp_rdata  in  DATA_WIDTH  slave-bus read data
- busy  out  1  arbiter is not in IDLE

Function
REQ-003 The arbiter SHALL keep one transaction outstanding at most, using the states IDLE, GNT and RSP.
REQ-004 In IDLE with any m_req_valid bit set, the arbiter SHALL:
- latch owner by round-robin: the requester other than last_owner wins a tie, a lone requester wins outright;
- enter GNT on the next cycle.
REQ-005 In IDLE the arbiter SHALL drive s_req_valid=0, m_req_ready=0 and m_rsp_valid=0.
REQ-006 In GNT, the slave-side request outputs SHALL be driven as follows:
- s_req_valid = m_req_valid[owner];
- s_req_addr, s_req_write and s_req_wdata = the owner's slices, combinationally;
- m_req_ready[owner] = s_req_ready;
- m_req_ready of the non-owner = 0.
REQ-007 On a GNT handshake (s_req_valid & s_req_ready), the arbiter SHALL:
- go to IDLE for a write;
- go to RSP for a read;
- in both cases set last_owner = owner.
REQ-008 If m_req_valid[owner] drops while in GNT without a handshake, the arbiter SHALL return to IDLE and leave last_owner unchanged.
REQ-009 When s_req_valid=0, s_req_addr, s_req_write and s_req_wdata SHALL be don't-care. The non-owner's inputs SHALL never reach the slave.
REQ-010 In RSP, s_rsp_valid=1 SHALL cause, in the same cycle, combinationally:
- m_rsp_valid[owner]=1;
- m_rsp_rdata=s_rsp_rdata;
- m_rsp_err=0.
The arbiter SHALL then go to IDLE.
REQ-011 A timeout counter SHALL clear on entry to RSP and increment each RSP cycle without s_rsp_valid.
REQ-012 When the timeout counter reaches RSP_TIMEOUT, the arbiter SHALL:
- pulse m_rsp_valid[owner]=1 with m_rsp_rdata=0 and m_rsp_err=1;
- go to IDLE.
REQ-013 If s_rsp_valid and the timeout coincide, the real response SHALL win (m_rsp_err=0).
REQ-014 s_rsp_valid outside RSP SHALL be ignored: no m_rsp_valid pulse and no state change.
REQ-015 m_rsp_valid, m_rsp_err and m_req_ready SHALL be 0 in every state except as stated above.
REQ-016 Minimum latency SHALL be:
- m_req_valid rising in IDLE at cycle N -> s_req_valid at N+1;
- with s_req_ready=1 at N+1, the handshake completes at N+1;
- the next arbitration happens in IDLE at N+2.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 The timeout counter SHALL be $clog2(RSP_TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-019 rst=1 at a posedge SHALL force, on the next cycle:
- state=IDLE, last_owner=1 (so requester 0 wins the first tie), timeout counter=0;
- all m_req_ready, m_rsp_valid, m_rsp_err, s_req_valid and busy = 0.
REQ-020 Reset asserted mid-transaction (GNT or RSP) SHALL abandon the transaction without a response pulse. A late s_rsp_valid after reset SHALL be ignored per REQ-014.

Verification
REQ-021 Single write: m_req_valid=01, addr=0x1234, wdata=0xBEEF, write=1, s_req_ready=1 -> the following must hold:
- next cycle: s_req_valid=1, s_req_addr=0x1234, s_req_wdata=0xBEEF, m_req_ready=01;
- the cycle after: busy=0.
REQ-022 Read with 3-cycle slave latency: requester 1 reads addr 0x0040; s_rsp_valid arrives 3 cycles after the handshake with rdata 0xA5A5 -> required response:
- m_rsp_valid=10, m_rsp_rdata=0xA5A5, m_rsp_err=0;
- m_rsp_valid[0] stays 0 throughout.
REQ-023 Round-robin: both requesters hold continuous write requests with s_req_ready=1 -> grants SHALL alternate 0,1,0,1 starting with requester 0 after reset.
REQ-024 Timeout: RSP_TIMEOUT=8, a read is accepted and s_rsp_valid is never asserted -> after 8 RSP cycles, a single cycle of m_rsp_valid[owner]=1, m_rsp_err=1, m_rsp_rdata=0, then IDLE.
REQ-025 Backpressure and abort: s_req_ready held 0 for 5 cycles, owner drops m_req_valid in cycle 3 -> the arbiter returns to IDLE, no m_req_ready pulse, last_owner unchanged.
REQ-026 Reset in RSP: assert rst for 1 cycle while in RSP, then pulse s_rsp_valid -> no m_rsp_valid pulse, busy=0.
